// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB-first, carry
// recirculated through a flop, operands in and result out over valid/ready.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] w_sum_sh_nxt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_s;
  logic             w_fa_co;
  logic             w_last;

  Full_adder u_fa (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .cin (r_carry),
    .s   (w_fa_s),
    .cout(w_fa_co)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 holds the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_sh_nxt = w_fa_s;
    end else begin : g_wn
      assign w_sum_sh_nxt = {w_fa_s, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.in_ready = rst_n;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_sh_nxt;
          r_carry  <= w_fa_co;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= w_sum_sh_nxt;
            r_cout <= w_fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed WIDTH=8 cases plus randomized traffic
// at WIDTH=1/8/16 against a cycle-count model of the handshake and a+b+cin.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic r_rst_n = 1'b0;
  logic d_rst_n = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Directed instance
  serial_add_ctrl_if #(.WIDTH(8)) dbus ();
  serial_add_ctrl #(.WIDTH(8)) u_dut (.clk(clk), .rst_n(d_rst_n), .bus(dbus));

  // Random instances, each with its own model and compare process
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 8 : 16;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

    serial_add_ctrl_if #(.WIDTH(W)) rbus ();
    serial_add_ctrl #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(r_rst_n), .bus(rbus));

    bit              m_idle = 1'b1;
    int              m_left = 0;
    bit              m_done = 1'b0;
    longint unsigned m_pend = 0;
    longint unsigned m_last = 0;
    int              n_res  = 0;
    bit              fin    = 1'b0;

    initial begin
      rbus.in_valid  = 1'b0;
      rbus.a         = '0;
      rbus.b         = '0;
      rbus.cin       = 1'b0;
      rbus.out_ready = 1'b0;
      wait (r_rst_n === 1'b1);
      while (n_res < 500) begin
        @(posedge clk);
        #1;
        rbus.in_valid  = ($urandom_range(3) != 0);
        rbus.a         = W'($urandom);
        rbus.b         = W'($urandom);
        rbus.cin       = 1'($urandom);
        rbus.out_ready = ($urandom_range(2) != 0);
      end
      fin = 1'b1;
    end

    always @(negedge clk) begin
      if (r_rst_n) begin
        chk($sformatf("w%0d_in_ready", W), rbus.in_ready, m_idle);
        chk($sformatf("w%0d_busy", W), rbus.busy, m_left > 0);
        chk($sformatf("w%0d_out_valid", W), rbus.out_valid, m_done);
        chk($sformatf("w%0d_sum", W), rbus.sum, m_last & MASK);
        chk($sformatf("w%0d_cout", W), rbus.cout, (m_last >> W) & 64'd1);
        // advance model to what must hold after the coming edge
        if (m_idle) begin
          if (rbus.in_valid) begin
            m_pend = (longint'(rbus.a) + longint'(rbus.b) + longint'(rbus.cin)) & ((MASK << 1) | 64'd1);
            m_left = W;
            m_idle = 1'b0;
          end
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            m_last = m_pend;
          end
        end else if (m_done && rbus.out_ready) begin
          m_done = 1'b0;
          m_idle = 1'b1;
          n_res++;
        end
      end
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec, input string nm, input bit bp);
    @(posedge clk); #1;
    dbus.in_valid = 1'b1; dbus.a = a; dbus.b = b; dbus.cin = ci; dbus.out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_accept_rdy"}, dbus.in_ready, 1);
    @(posedge clk); #1;
    dbus.in_valid = 1'b0; dbus.a = ~a; dbus.b = ~b; dbus.cin = ~ci;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("%s_run%0d_busy", nm, k), dbus.busy, 1);
      chk($sformatf("%s_run%0d_ovalid", nm, k), dbus.out_valid, 0);
      chk($sformatf("%s_run%0d_irdy", nm, k), dbus.in_ready, 0);
    end
    @(negedge clk);
    chk({nm, "_ovalid"}, dbus.out_valid, 1);
    chk({nm, "_busy_done"}, dbus.busy, 0);
    chk({nm, "_sum"}, dbus.sum, es);
    chk({nm, "_cout"}, dbus.cout, ec);
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        dbus.in_valid = ~dbus.in_valid;
        dbus.a = 8'($urandom); dbus.b = 8'($urandom);
        @(negedge clk);
        chk($sformatf("%s_bp%0d_ovalid", nm, k), dbus.out_valid, 1);
        chk($sformatf("%s_bp%0d_irdy", nm, k), dbus.in_ready, 0);
        chk($sformatf("%s_bp%0d_busy", nm, k), dbus.busy, 0);
        chk($sformatf("%s_bp%0d_sum", nm, k), dbus.sum, es);
        chk($sformatf("%s_bp%0d_cout", nm, k), dbus.cout, ec);
      end
    end
    @(posedge clk); #1;
    dbus.in_valid = 1'b0; dbus.out_ready = 1'b1;
    @(posedge clk); #1;
    dbus.out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_ovalid"}, dbus.out_valid, 0);
    chk({nm, "_idle_irdy"}, dbus.in_ready, 1);
    chk({nm, "_idle_busy"}, dbus.busy, 0);
    chk({nm, "_held_sum"}, dbus.sum, es);
    chk({nm, "_held_cout"}, dbus.cout, ec);
  endtask

  initial begin
    longint unsigned q[$];
    longint unsigned exp;
    int last_t;
    int n;
    dbus.in_valid = 1'b0; dbus.a = '0; dbus.b = '0; dbus.cin = 1'b0; dbus.out_ready = 1'b0;
    #12 r_rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", dbus.in_ready, 0);
    chk("rst_out_valid", dbus.out_valid, 0);
    chk("rst_busy", dbus.busy, 0);
    chk("rst_sum", dbus.sum, 0);
    chk("rst_cout", dbus.cout, 0);
    @(posedge clk); #2 d_rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", dbus.in_ready, 1);

    do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero", 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01", 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_c", 1'b0);
    do_op(8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0, "3c_41_bp", 1'b1);

    // Asynchronous reset in the middle of a run
    @(posedge clk); #1;
    dbus.in_valid = 1'b1; dbus.a = 8'hFF; dbus.b = 8'hFF; dbus.cin = 1'b0;
    @(posedge clk); #1;
    dbus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_pre_busy", dbus.busy, 1);
    #2 d_rst_n = 1'b0;
    #1;
    chk("arst_in_ready", dbus.in_ready, 0);
    chk("arst_out_valid", dbus.out_valid, 0);
    chk("arst_busy", dbus.busy, 0);
    chk("arst_sum", dbus.sum, 0);
    chk("arst_cout", dbus.cout, 0);
    @(posedge clk); #2 d_rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_in_ready", dbus.in_ready, 1);
    chk("arst_rel_out_valid", dbus.out_valid, 0);
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "post_rst", 1'b0);

    // Back-to-back with in_valid and out_ready held high, operands churning
    last_t = -1;
    n = 0;
    @(posedge clk); #1;
    dbus.in_valid = 1'b1; dbus.out_ready = 1'b1;
    dbus.a = 8'($urandom); dbus.b = 8'($urandom); dbus.cin = 1'($urandom);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dbus.out_valid) begin
        if (q.size() == 0) begin
          chk("b2b_unexpected_result", dbus.out_valid, 0);
        end else begin
          exp = q.pop_front();
          chk("b2b_sum", dbus.sum, exp & 64'hFF);
          chk("b2b_cout", dbus.cout, (exp >> 8) & 64'd1);
        end
        if (last_t >= 0) chk("b2b_period", 64'(c - last_t), 10);
        last_t = c;
        n++;
      end
      if (dbus.in_ready && dbus.in_valid)
        q.push_back(longint'(dbus.a) + longint'(dbus.b) + longint'(dbus.cin));
      @(posedge clk); #1;
      dbus.a = 8'($urandom); dbus.b = 8'($urandom); dbus.cin = 1'($urandom);
    end
    chk("b2b_count", 64'(n), 6);
    dbus.in_valid = 1'b0;

    for (int i = 0; i < 60000; i++) begin
      if (g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) break;
      @(posedge clk);
    end
    chk("rnd_w1_done", g_rnd[0].fin, 1);
    chk("rnd_w8_done", g_rnd[1].fin, 1);
    chk("rnd_w16_done", g_rnd[2].fin, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
